// File: rtl/wd_reset_ctrl.sv
// Reset stretcher for a watchdog: turns reset/fail edges into a fixed-width SYSRST_N pulse
// with a post-release blanking window, tracks fail history and locks out after MAXFAIL fails.
`timescale 1ns/1ps
module wd_reset_ctrl #(
    parameter int unsigned STRETCH = 16,
    parameter int unsigned HOLDOFF = 4,
    parameter int unsigned MAXFAIL = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RSTIN,
    input  logic       WDFAIL,
    input  logic [1:0] FLSTAT,
    input  logic       CLRFAIL,
    output logic       SYSRST_N,
    output logic [3:0] FAILCNT,
    output logic [1:0] LASTFL,
    output logic       LOCKOUT,
    output logic       BUSY
);

    typedef enum logic [1:0] {IDLE, ASSERT, HOLD, LOCK} state_t;

    localparam logic [7:0] STR_LAST  = 8'(STRETCH - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF - 1);
    localparam logic [3:0] MAXF      = 4'(MAXFAIL);

    state_t     state;
    logic [7:0] cnt;
    logic       pending;
    logic       rstin_q;
    logic       wdfail_q;

    logic       rst_edge;
    logic       wf_edge;
    logic       any_edge;
    logic [3:0] fc_base;
    logic [3:0] fc_next;
    logic       hit_max;

    // Clear is applied before the increment so CLRFAIL with a fail edge yields a count of 1.
    always_comb begin
        rst_edge = RSTIN & ~rstin_q;
        wf_edge  = WDFAIL & ~wdfail_q;
        any_edge = rst_edge | wf_edge;
        fc_base  = CLRFAIL ? '0 : FAILCNT;
        fc_next  = fc_base;
        if (wf_edge && (fc_base != 4'hF))
            fc_next = fc_base + 4'd1;
        hit_max  = wf_edge && (fc_next == MAXF);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= ASSERT;
            cnt      <= '0;
            pending  <= 1'b0;
            rstin_q  <= 1'b0;
            wdfail_q <= 1'b0;
            SYSRST_N <= 1'b0;
            FAILCNT  <= '0;
            LASTFL   <= '0;
            LOCKOUT  <= 1'b0;
            BUSY     <= 1'b1;
        end else begin
            rstin_q  <= RSTIN;
            wdfail_q <= WDFAIL;
            if (state != LOCK) begin
                FAILCNT <= fc_next;
                if (wf_edge)
                    LASTFL <= FLSTAT;
                if (hit_max) begin
                    state    <= LOCK;
                    cnt      <= '0;
                    pending  <= 1'b0;
                    SYSRST_N <= 1'b0;
                    LOCKOUT  <= 1'b1;
                    BUSY     <= 1'b1;
                end else begin
                    case (state)
                        IDLE: begin
                            if (any_edge) begin
                                state    <= ASSERT;
                                cnt      <= '0;
                                SYSRST_N <= 1'b0;
                                BUSY     <= 1'b1;
                            end
                        end
                        ASSERT: begin
                            if (cnt == STR_LAST) begin
                                state    <= HOLD;
                                cnt      <= '0;
                                SYSRST_N <= 1'b1;
                            end else begin
                                cnt <= cnt + 8'd1;
                            end
                        end
                        HOLD: begin
                            if (cnt == HOLD_LAST) begin
                                cnt     <= '0;
                                pending <= 1'b0;
                                // An edge on the final blanking cycle counts as pending too.
                                if (pending || any_edge) begin
                                    state    <= ASSERT;
                                    SYSRST_N <= 1'b0;
                                end else begin
                                    state <= IDLE;
                                    BUSY  <= 1'b0;
                                end
                            end else begin
                                cnt <= cnt + 8'd1;
                                if (any_edge)
                                    pending <= 1'b1;
                            end
                        end
                        LOCK: ;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_wd_reset_ctrl.sv
// Directed bench for wd_reset_ctrl with STRETCH=4, HOLDOFF=2, MAXFAIL=3.
`timescale 1ns/1ps
module tb_wd_reset_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RSTIN = 1'b0;
    logic       WDFAIL = 1'b0;
    logic [1:0] FLSTAT = 2'b00;
    logic       CLRFAIL = 1'b0;
    logic       SYSRST_N;
    logic [3:0] FAILCNT;
    logic [1:0] LASTFL;
    logic       LOCKOUT;
    logic       BUSY;

    int unsigned tests = 0;
    int unsigned fails = 0;

    typedef struct {
        logic       r;
        logic       w;
        logic [1:0] fs;
        logic       c;
        logic       sys;
        logic [3:0] fc;
        logic [1:0] lf;
        logic       lk;
        logic       b;
    } vec_t;

    vec_t tbl[$];

    wd_reset_ctrl #(.STRETCH(4), .HOLDOFF(2), .MAXFAIL(3)) dut (
        .CLK(CLK), .RST(RST), .RSTIN(RSTIN), .WDFAIL(WDFAIL), .FLSTAT(FLSTAT),
        .CLRFAIL(CLRFAIL), .SYSRST_N(SYSRST_N), .FAILCNT(FAILCNT), .LASTFL(LASTFL),
        .LOCKOUT(LOCKOUT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic add(input logic r, input logic w, input logic [1:0] fs, input logic c,
                       input logic sys, input logic [3:0] fc, input logic [1:0] lf,
                       input logic lk, input logic b);
        vec_t v;
        v.r = r; v.w = w; v.fs = fs; v.c = c;
        v.sys = sys; v.fc = fc; v.lf = lf; v.lk = lk; v.b = b;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic sys, input logic [3:0] fc,
                         input logic [1:0] lf, input logic lk, input logic b);
        tests++;
        if ({SYSRST_N, FAILCNT, LASTFL, LOCKOUT, BUSY} !== {sys, fc, lf, lk, b}) begin
            fails++;
            $display("FAIL %s: got sys=%b fc=%0d lf=%b lock=%b busy=%b, expected sys=%b fc=%0d lf=%b lock=%b busy=%b",
                     nm, SYSRST_N, FAILCNT, LASTFL, LOCKOUT, BUSY, sys, fc, lf, lk, b);
        end
    endtask

    // Drive inputs, then sample 1ns after the next rising edge.
    task automatic step(input logic r, input logic w, input logic [1:0] fs, input logic c);
        RSTIN = r; WDFAIL = w; FLSTAT = fs; CLRFAIL = c;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // power-on stretch
        add(0,0,0,0, 0,0,0,0,1); add(0,0,0,0, 0,0,0,0,1); add(0,0,0,0, 0,0,0,0,1);
        add(0,0,0,0, 1,0,0,0,1); add(0,0,0,0, 1,0,0,0,1);
        add(0,0,0,0, 1,0,0,0,0); add(0,0,0,0, 1,0,0,0,0);
        // RSTIN pulse in IDLE
        add(1,0,0,0, 0,0,0,0,1); add(0,0,0,0, 0,0,0,0,1); add(0,0,0,0, 0,0,0,0,1);
        add(0,0,0,0, 0,0,0,0,1); add(0,0,0,0, 1,0,0,0,1); add(0,0,0,0, 1,0,0,0,1);
        add(0,0,0,0, 1,0,0,0,0);
        // WDFAIL with FLSTAT=10, then RSTIN in first HOLD cycle -> back-to-back reset
        add(0,1,2,0, 0,1,2,0,1); add(0,0,0,0, 0,1,2,0,1); add(0,0,0,0, 0,1,2,0,1);
        add(0,0,0,0, 0,1,2,0,1); add(0,0,0,0, 1,1,2,0,1); add(1,0,0,0, 1,1,2,0,1);
        add(0,0,0,0, 0,1,2,0,1); add(0,0,0,0, 0,1,2,0,1); add(0,0,0,0, 0,1,2,0,1);
        add(0,0,0,0, 0,1,2,0,1); add(0,0,0,0, 1,1,2,0,1); add(0,0,0,0, 1,1,2,0,1);
        add(0,0,0,0, 1,1,2,0,0);
        // CLRFAIL alone, then CLRFAIL with fail edge; held WDFAIL must not retrigger
        add(0,0,0,1, 1,0,2,0,0); add(0,1,1,1, 0,1,1,0,1); add(0,1,0,0, 0,1,1,0,1);
        add(0,0,0,0, 0,1,1,0,1); add(0,0,0,0, 0,1,1,0,1); add(0,0,0,0, 1,1,1,0,1);
        add(0,0,0,0, 1,1,1,0,1); add(0,0,0,0, 1,1,1,0,0);
        // simultaneous RSTIN+WDFAIL: one event, one increment
        add(1,1,3,0, 0,2,3,0,1); add(0,0,0,0, 0,2,3,0,1); add(0,0,0,0, 0,2,3,0,1);
        add(0,0,0,0, 0,2,3,0,1); add(0,0,0,0, 1,2,3,0,1); add(0,0,0,0, 1,2,3,0,1);
        add(0,0,0,0, 1,2,3,0,0);
        // third fail -> LOCK; inputs ignored afterwards
        add(0,1,1,0, 0,3,1,1,1); add(1,0,0,1, 0,3,1,1,1); add(0,1,2,0, 0,3,1,1,1);
        add(0,0,0,0, 0,3,1,1,1);

        repeat (2) @(posedge CLK);
        #1;
        check("reset_hold", 0, 0, 0, 0, 1);
        RST = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].w, tbl[i].fs, tbl[i].c);
            check($sformatf("vec%0d", i), tbl[i].sys, tbl[i].fc, tbl[i].lf, tbl[i].lk, tbl[i].b);
        end

        // asynchronous reset out of LOCK, observed before the next edge
        #3 RST = 1'b0;
        #1 check("async_rst_lock", 0, 0, 0, 0, 1);
        #2 RST = 1'b1;

        // three WDFAIL pulses 10 cycles apart
        repeat (6) step(0,0,0,0);
        check("idle_before_pulses", 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0,1,2'(k),0);
            check($sformatf("pulse%0d", k), 0, 4'(k + 1), 2'(k), (k == 2), 1);
            repeat (9) step(0,0,0,0);
        end
        check("locked_after_pulses", 0, 3, 2, 1, 1);
        step(1,0,0,1);
        check("lock_ignores_clr_rstin", 0, 3, 2, 1, 1);

        #3 RST = 1'b0;
        #1 check("rst_clears_lock", 0, 0, 0, 0, 1);
        #2 RST = 1'b1;

        // reset at cycle 2 of an ASSERT started by a fail
        repeat (6) step(0,0,0,0);
        step(0,1,3,0);
        check("fail_before_midassert", 0, 1, 3, 0, 1);
        step(0,0,0,0);
        step(0,0,0,0);
        #3 RST = 1'b0;
        #1 check("async_rst_midassert", 0, 0, 0, 0, 1);
        #2 RST = 1'b1;
        repeat (4) step(0,0,0,0);
        check("post_rst_stretch_done", 1, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wd_reset_ctrl.md
WD_RESET_CTRL -- requirements
Module: wd_reset_ctrl

Interface
REQ-001 Parameter STRETCH, default 16: number of cycles SYSRST_N is held low per reset event; legal range 1..255.
REQ-002 Parameter HOLDOFF, default 4: blanking cycles after SYSRST_N release; legal range 1..255.
REQ-003 Parameter MAXFAIL, default 3: watchdog fail count that forces lockout; legal range 1..15.
REQ-004 CLK  input  1  the single clock; all state changes on its rising edge.
REQ-005 RST  input  1  asynchronous, active-low reset.
REQ-006 RSTIN  input  1  reset request from the watchdog (its RSTOUT); active-high, rising-edge detected.
REQ-007 WDFAIL  input  1  watchdog fail indication; active-high, rising-edge detected.
REQ-008 FLSTAT  input  2  fail code from the watchdog; sampled on each WDFAIL rising edge.
REQ-009 CLRFAIL  input  1  software clear of the fail counter; level, sampled each cycle.
REQ-010 SYSRST_N  output  1  stretched system reset, active-low, registered.
REQ-011 FAILCNT  output  4  count of WDFAIL rising edges since the last clear.
REQ-012 LASTFL  output  2  FLSTAT captured at the most recent WDFAIL rising edge.
REQ-013 LOCKOUT  output  1  high while the block is locked after MAXFAIL fails.
REQ-014 BUSY  output  1  high whenever the state is not IDLE.

Function
REQ-015 Edge detection SHALL use a one-cycle registered copy of RSTIN and WDFAIL: edge = input high AND registered copy low.
REQ-016 FSM states SHALL be IDLE, ASSERT, HOLD, LOCK.
REQ-017 In IDLE, an RSTIN or WDFAIL edge SHALL move the FSM to ASSERT; SYSRST_N goes low on that same clock edge.
REQ-018 ASSERT SHALL keep SYSRST_N low for exactly STRETCH cycles; the FSM then enters HOLD with SYSRST_N high.
REQ-019 HOLD SHALL last exactly HOLDOFF cycles with SYSRST_N high; the FSM then returns to IDLE.
REQ-020 An RSTIN or WDFAIL edge during ASSERT SHALL be ignored for reset purposes (no extension).
REQ-021 An RSTIN or WDFAIL edge during HOLD SHALL set a pending flag.
- At the end of HOLD with pending set, the FSM SHALL go directly to ASSERT (SYSRST_N low on that edge) and clear pending.
REQ-022 Every WDFAIL edge in IDLE, ASSERT or HOLD SHALL increment FAILCNT (saturating at 15) and capture FLSTAT into LASTFL.
REQ-023 When FAILCNT becomes equal to MAXFAIL, the FSM SHALL enter LOCK on the same edge.
- In LOCK: SYSRST_N is low, LOCKOUT is high, all inputs are ignored.
- LOCK exits only via RST.
REQ-024 CLRFAIL high outside LOCK SHALL set FAILCNT to 0.
- If CLRFAIL coincides with a WDFAIL edge, the result SHALL be FAILCNT = 1 (clear first, then increment).
REQ-025 Simultaneous RSTIN and WDFAIL edges SHALL produce one reset event and a single FAILCNT increment.
REQ-026 The STRETCH/HOLDOFF cycle counter SHALL be 8 bits, load 0 on state entry, and compare against parameter-1; it never wraps.
REQ-027 BUSY SHALL be high in ASSERT, HOLD and LOCK.

Reset
REQ-028 While RST is low, the block SHALL hold these values:
- state ASSERT with counter 0, SYSRST_N=0;
- FAILCNT=0, LASTFL=2'b00, LOCKOUT=0, BUSY=1;
- pending=0, edge registers=0.
REQ-029 After RST rises, the block SHALL complete the normal ASSERT (STRETCH cycles) then HOLD sequence; this is the power-on reset stretch.
REQ-030 RST asserted in any state, including mid-ASSERT or LOCK, SHALL immediately force the REQ-028 values.

Verification (STRETCH=4, HOLDOFF=2, MAXFAIL=3)
REQ-031 Release RST -> SYSRST_N low 4 cycles then high; BUSY high 6 cycles then low; FAILCNT=0.
REQ-032 One-cycle RSTIN pulse in IDLE -> SYSRST_N low exactly 4 cycles starting at the sampling edge; FAILCNT stays 0.
REQ-033 WDFAIL pulse with FLSTAT=2'b10 in IDLE -> FAILCNT=1, LASTFL=2'b10, SYSRST_N low 4 cycles.
REQ-034 RSTIN pulse in the 1st HOLD cycle -> second 4-cycle SYSRST_N low period begins immediately after the 2 HOLD cycles, with no IDLE cycle in between.
REQ-035 Three WDFAIL pulses spaced 10 cycles apart -> LOCKOUT=1 and SYSRST_N=0 from the 3rd edge onward. Then:
- CLRFAIL and RSTIN have no effect while locked;
- RST low clears LOCKOUT and FAILCNT.
REQ-036 RST low at cycle 2 of ASSERT -> all outputs return to REQ-028 values asynchronously, before the next clock edge.
